// File: rtl/baud_pkg.sv
// Shared constants and the reset-divisor computation for the baud tick generator.
package baud_pkg;

    localparam int DEF_INT_W  = 32'sd16;
    localparam int DEF_FRAC_W = 32'sd8;
    localparam int MIN_DIV    = 32'sd2;

    // Clocks per oversample tick in fixed point with frac_w fraction bits, rounded to nearest.
    function automatic longint unsigned calc_rst_div(
        input longint unsigned clock_freq,
        input longint unsigned baud_rate,
        input longint unsigned oversample,
        input int              frac_w
    );
        longint unsigned num;
        longint unsigned den;
        num = clock_freq << frac_w;
        den = baud_rate * oversample;
        return (num + (den / 64'd2)) / den;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds the divisor fraction on every tick and
// exposes the carry as a one-clock period extension for the following period.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clock,
    input  logic              reset_n_i,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              extra_o
);

    logic [FRAC_W-1:0] acc_r;
    logic              extra_r;
    logic [FRAC_W:0]   sum_s;

    // Next accumulator value with carry out
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, div_frac_i};
    end

    // Accumulator and carry register; phase restart wins over a step
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_r   <= '0;
            extra_r <= 1'b0;
        end else if (clear_i) begin
            acc_r   <= '0;
            extra_r <= 1'b0;
        end else if (step_i) begin
            {extra_r, acc_r} <= sum_s;
        end else begin
            acc_r   <= acc_r;
            extra_r <= extra_r;
        end
    end

    assign extra_o = extra_r;

endmodule

// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator (oversample tick + bit tick) with a
// staged divisor update. Define BAUD_FRAC_EN to enable the fractional divisor.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 32'd10_000_000,
    parameter int unsigned BAUD_RATE  = 32'd9600,
    parameter int unsigned OVERSAMPLE = 32'd16,
    parameter int          INT_W      = DEF_INT_W,
    parameter int          FRAC_W     = DEF_FRAC_W
) (
    input  logic              clock,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic              sync_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [INT_W-1:0]  cfg_int_i,
    input  logic [FRAC_W-1:0] cfg_frac_i,
    output logic              tick_o,
    output logic              bit_tick_o,
    output logic              busy_o
);

    localparam int CNT_W = INT_W + 32'sd1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
`ifdef BAUD_FRAC_EN
    localparam int FW = FRAC_W;
`else
    localparam int FW = 32'sd0;
`endif
    localparam longint unsigned RST_DIV =
        calc_rst_div(64'(CLOCK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE), FW);
    localparam logic [INT_W-1:0] RST_INT  = INT_W'(RST_DIV >> FW);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 32'd1);
    localparam logic [INT_W-1:0] MIN_INT  = INT_W'(MIN_DIV);

    logic [INT_W-1:0] div_int_r;
    logic [INT_W-1:0] shd_int_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [OS_W-1:0]  os_cnt_r;
    logic [OS_W-1:0]  os_nxt_s;
    logic [CNT_W-1:0] period_end_s;
    logic [INT_W-1:0] cfg_int_clamped_s;
    logic             extra_s;
    logic             tick_s;
    logic             bit_tick_s;
    logic             accept_s;
    logic             apply_s;

    // Tick decode, handshake and apply conditions
    always_comb begin
        period_end_s = {1'b0, div_int_r} + {{INT_W{1'b0}}, extra_s} - CNT_W'(1'b1);
        // >= rather than == so a divisor shrunk below the running count still ends the period
        tick_s       = enable_i && !sync_i && (cnt_r >= period_end_s);
        bit_tick_s   = tick_s && (os_cnt_r == OS_LAST);
        accept_s     = cfg_valid_i && !busy_r;
        apply_s      = busy_r && (tick_s || !enable_i || sync_i);
        if (cfg_int_i < MIN_INT) begin
            cfg_int_clamped_s = MIN_INT;
        end else begin
            cfg_int_clamped_s = cfg_int_i;
        end
    end

    // Next state for the period and oversample counters
    always_comb begin
        cnt_nxt_s = cnt_r;
        os_nxt_s  = os_cnt_r;
        if (enable_i && sync_i) begin
            cnt_nxt_s = '0;
            os_nxt_s  = '0;
        end else if (tick_s) begin
            cnt_nxt_s = '0;
            if (os_cnt_r == OS_LAST) begin
                os_nxt_s = '0;
            end else begin
                os_nxt_s = os_cnt_r + OS_W'(1'b1);
            end
        end else if (enable_i) begin
            cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_nxt_s = cnt_r;
            os_nxt_s  = os_cnt_r;
        end
    end

    // Counter state registers
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r    <= '0;
            os_cnt_r <= '0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            os_cnt_r <= os_nxt_s;
        end
    end

    // Shadow capture and busy flag; accept and apply are mutually exclusive
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_r    <= 1'b0;
            shd_int_r <= '0;
        end else if (apply_s) begin
            busy_r    <= 1'b0;
            shd_int_r <= shd_int_r;
        end else if (accept_s) begin
            busy_r    <= 1'b1;
            shd_int_r <= cfg_int_clamped_s;
        end else begin
            busy_r    <= busy_r;
            shd_int_r <= shd_int_r;
        end
    end

    // Active integer divisor
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_int_r <= RST_INT;
        end else if (apply_s) begin
            div_int_r <= shd_int_r;
        end else begin
            div_int_r <= div_int_r;
        end
    end

`ifdef BAUD_FRAC_EN
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV);

    logic [FRAC_W-1:0] div_frac_r;
    logic [FRAC_W-1:0] shd_frac_r;

    // Fractional shadow and active fraction follow the integer staging
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shd_frac_r <= '0;
            div_frac_r <= RST_FRAC;
        end else if (apply_s) begin
            shd_frac_r <= shd_frac_r;
            div_frac_r <= shd_frac_r;
        end else if (accept_s) begin
            shd_frac_r <= cfg_frac_i;
            div_frac_r <= div_frac_r;
        end else begin
            shd_frac_r <= shd_frac_r;
            div_frac_r <= div_frac_r;
        end
    end

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clock      (clock),
        .reset_n_i  (reset_n_i),
        .clear_i    (enable_i && sync_i),
        .step_i     (tick_s),
        .div_frac_i (div_frac_r),
        .extra_o    (extra_s)
    );
`else
    logic frac_unused_s;

    assign extra_s       = 1'b0;
    assign frac_unused_s = ^cfg_frac_i;
`endif

    assign tick_o      = tick_s;
    assign bit_tick_o  = bit_tick_s;
    assign busy_o      = busy_r;
    assign cfg_ready_o = !busy_r;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen; expectations follow BAUD_FRAC_EN.
`timescale 1ns/1ps
module tb_baud_tick_gen;

`ifdef BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n_i;
    logic        enable_i;
    logic        sync_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [15:0] cfg_int_i;
    logic [7:0]  cfg_frac_i;
    logic        tick_o;
    logic        bit_tick_o;
    logic        busy_o;

    int cyc = 0;
    int base = 0;
    int n_checks = 0;
    int n_fail = 0;
    int orphan = 0;
    int tq[$];
    int bq[$];

    baud_tick_gen dut (
        .clock       (clock),
        .reset_n_i   (reset_n_i),
        .enable_i    (enable_i),
        .sync_i      (sync_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_int_i   (cfg_int_i),
        .cfg_frac_i  (cfg_frac_i),
        .tick_o      (tick_o),
        .bit_tick_o  (bit_tick_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record tick times mid-cycle
    always @(negedge clock) begin
        if (tick_o) tq.push_back(cyc);
        if (bit_tick_o) bq.push_back(cyc);
        if (bit_tick_o && !tick_o) orphan = orphan + 1;
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int rel);
        while (cyc < base + rel) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_ticks(input int n, input int budget);
        while (tq.size() < n && cyc < base + budget) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int tick_rel(input int i);
        if (tq.size() > i) return tq[i] - base;
        return -1;
    endfunction

    function automatic int bit_rel(input int i);
        if (bq.size() > i) return bq[i] - base;
        return -1;
    endfunction

    task automatic restart();
        @(posedge clock);
        #1;
        reset_n_i   = 1'b0;
        enable_i    = 1'b0;
        sync_i      = 1'b0;
        cfg_valid_i = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tq.delete();
        bq.delete();
        reset_n_i = 1'b1;
        enable_i  = 1'b1;
        base      = cyc;
    endtask

    initial begin
        reset_n_i   = 1'b0;
        enable_i    = 1'b1;
        sync_i      = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_int_i   = 16'd0;
        cfg_frac_i  = 8'd0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_ready", cfg_ready_o, 1);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_tick", tick_o, 0);
        check_val("rst_bit_tick", bit_tick_o, 0);

        // Default divisor over 1000 ticks
        @(posedge clock);
        #1;
        reset_n_i = 1'b1;
        base = cyc;
        wait_ticks(1000, 70000);
        check_val("dflt_count", tq.size(), 1000);
        check_val("dflt_first", tick_rel(0), 64);
        check_val("dflt_1000th", tick_rel(999), FRAC_ON ? 65104 : 64999);
        check_val("dflt_bits", bq.size(), 62);
        check_val("dflt_bit_first", bit_rel(0), FRAC_ON ? 1040 : 1039);
        check_val("dflt_bit_last", bit_rel(61), FRAC_ON ? 64583 : 64479);
        check_val("dflt_orphan", orphan, 0);

        // Config write mid-period, second offer held off while busy
        restart();
        go_to(30);
        cfg_valid_i = 1'b1;
        cfg_int_i   = 16'd10;
        cfg_frac_i  = 8'd128;
        @(negedge clock);
        check_val("cfg_ready_idle", cfg_ready_o, 1);
        go_to(31);
        cfg_int_i  = 16'd20;
        cfg_frac_i = 8'd0;
        @(negedge clock);
        check_val("cfg_busy_set", busy_o, 1);
        check_val("cfg_ready_busy", cfg_ready_o, 0);
        go_to(41);
        cfg_valid_i = 1'b0;
        go_to(64);
        @(negedge clock);
        check_val("cfg_busy_at_tick", busy_o, 1);
        check_val("cfg_tick_old", tick_o, 1);
        go_to(65);
        @(negedge clock);
        check_val("cfg_busy_clear", busy_o, 0);
        wait_ticks(6, 400);
        check_val("cfg_t1", tick_rel(1), 74);
        check_val("cfg_t2", tick_rel(2), 84);
        check_val("cfg_t3", tick_rel(3), FRAC_ON ? 95 : 94);
        check_val("cfg_t4", tick_rel(4), FRAC_ON ? 105 : 104);
        check_val("cfg_t5", tick_rel(5), FRAC_ON ? 116 : 114);

        // Clamp of cfg_int=1 to 2
        restart();
        cfg_valid_i = 1'b1;
        cfg_int_i   = 16'd1;
        cfg_frac_i  = 8'd0;
        go_to(1);
        cfg_valid_i = 1'b0;
        wait_ticks(4, 200);
        check_val("clamp_t0", tick_rel(0), 64);
        check_val("clamp_t1", tick_rel(1), 66);
        check_val("clamp_t2", tick_rel(2), 68);
        check_val("clamp_t3", tick_rel(3), 70);

        // sync_i early and coincident with a tick
        restart();
        go_to(124);
        sync_i = 1'b1;
        @(negedge clock);
        check_val("sync_early_tick", tick_o, 0);
        go_to(125);
        sync_i = 1'b0;
        go_to(189);
        sync_i = 1'b1;
        @(negedge clock);
        check_val("sync_coincident_tick", tick_o, 0);
        go_to(190);
        sync_i = 1'b0;
        while (bq.size() < 1 && cyc < base + 1400) begin
            @(posedge clock);
            #1;
        end
        check_val("sync_t0", tick_rel(0), 64);
        check_val("sync_t1", tick_rel(1), 254);
        check_val("sync_t2", tick_rel(2), 319);
        check_val("sync_bit", bit_rel(0), FRAC_ON ? 1230 : 1229);

        // enable_i low mid-period, then config while disabled
        restart();
        go_to(30);
        enable_i = 1'b0;
        go_to(130);
        enable_i = 1'b1;
        wait_ticks(1, 300);
        check_val("en_resume_t0", tick_rel(0), 164);
        go_to(170);
        enable_i = 1'b0;
        go_to(172);
        cfg_valid_i = 1'b1;
        cfg_int_i   = 16'd20;
        cfg_frac_i  = 8'd0;
        go_to(173);
        cfg_valid_i = 1'b0;
        @(negedge clock);
        check_val("en_busy_disabled", busy_o, 1);
        go_to(174);
        @(negedge clock);
        check_val("en_apply_disabled", busy_o, 0);
        go_to(180);
        enable_i = 1'b1;
        wait_ticks(3, 400);
        check_val("en_t1", tick_rel(1), 194);
        check_val("en_t2", tick_rel(2), 214);

        // Asynchronous reset mid-period with a staged divisor
        restart();
        go_to(10);
        cfg_valid_i = 1'b1;
        cfg_int_i   = 16'd10;
        cfg_frac_i  = 8'd0;
        go_to(11);
        cfg_valid_i = 1'b0;
        go_to(20);
        check_val("arst_busy_before", busy_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_val("arst_busy", busy_o, 0);
        check_val("arst_ready", cfg_ready_o, 1);
        check_val("arst_tick", tick_o, 0);
        repeat (2) @(posedge clock);
        #1;
        tq.delete();
        bq.delete();
        reset_n_i = 1'b1;
        base = cyc;
        wait_ticks(2, 200);
        check_val("arst_t0", tick_rel(0), 64);
        check_val("arst_t1", tick_rel(1), 129);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Runtime-programmable baud tick generator with fractional divisor, oversample tick and bit-rate tick. It replaces the fixed-divisor generator in front of the UART RX/TX pair of the MIPS debug link. The divisor can be reloaded at run time through a valid/ready handshake, and each update takes effect only on a tick boundary. A sync input lets the receiver realign the tick phase on a start-bit edge.

## Interface
- CLOCK_FREQ, 10000000: input clock frequency in Hz; used only for reset divisor.
- BAUD_RATE, 9600: reset baud rate.
- OVERSAMPLE, 16: oversample ticks per bit, 2..64.
- INT_W, 16: integer divisor width.
- FRAC_W, 8: fractional divisor width; ignored without BAUD_FRAC_EN.
- clock  in  1  system clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  run; low freezes all counters and suppresses ticks.
- sync_i  in  1  phase restart, one-cycle pulse.
- cfg_valid_i  in  1  new divisor offered.
- cfg_ready_o  out  1  divisor can be accepted.
- cfg_int_i  in  INT_W  integer part of clocks per oversample tick.
- cfg_frac_i  in  FRAC_W  fractional part, in units of 2^-FRAC_W.
- tick_o  out  1  oversample tick, one cycle wide.
- bit_tick_o  out  1  bit-rate tick, coincident with every OVERSAMPLE-th tick_o.
- busy_o  out  1  a staged divisor is waiting for a tick boundary.

## Operation
- Reset divisor: RST_DIV = CLOCK_FREQ·2^FRAC_W / (BAUD_RATE·OVERSAMPLE), rounded to nearest. With the defaults this is int 65, frac 27.
- Active registers: div_int, div_frac, cnt (INT_W+1 bits), acc (FRAC_W bits), extra (1 bit), os_cnt (ceil log2 OVERSAMPLE bits).
- Period length is div_int + extra. tick_o = enable_i && !sync_i && cnt == div_int + extra − 1.
- On a tick:
  - cnt ← 0.
  - {extra, acc} ← acc + div_frac, where extra is the carry.
  - os_cnt increments and wraps at OVERSAMPLE−1.
- Otherwise, while enabled, cnt increments by 1.
- bit_tick_o = tick_o && os_cnt == OVERSAMPLE−1.
- cfg_int_i values 0 and 1 are clamped to 2. The minimum tick period is 2 cycles.
- Config staging:
  - cfg_ready_o = !busy_o.
  - When cfg_valid_i && cfg_ready_o, the values are captured into shadow registers and busy_o is set.
  - The shadow is copied to div_int/div_frac on the cycle tick_o is high, or on the next cycle if enable_i is low. busy_o then clears.
  - A new period uses the new divisor. acc and os_cnt are not cleared on update.
- sync_i, while enabled:
  - cnt, acc, extra and os_cnt clear.
  - No tick in that cycle.
  - A pending config is also applied.
  - sync_i has priority over a coincident tick.
- enable_i low: all state holds except config apply. Outputs tick_o and bit_tick_o are 0.
- Reset mid-period: all state returns to reset values immediately. The shadow is discarded.

## Timing
- Reset values:
  - tick_o 0, bit_tick_o 0, busy_o 0, cfg_ready_o 1.
  - cnt, acc, extra, os_cnt 0; div = RST_DIV.
- After reset release with enable_i high, the first tick_o occurs in cycle div_int (0-based counting from the first enabled edge). With the defaults that is cycle 64.
- Ticks are registered-state decodes: combinational from cnt/os_cnt/enable_i/sync_i. They are not registered outputs.
- Config latency: accept at cycle t; the new period begins at the cycle after the next tick_o. busy_o is high from t+1 until that tick.
- Average tick period = div_int + div_frac/2^FRAC_W. Jitter is at most 1 clock.

## Configuration
- BAUD_FRAC_EN defined: fractional accumulator present as above.
- BAUD_FRAC_EN undefined:
  - acc/extra are removed, extra is constant 0, and cfg_frac_i is ignored.
  - RST_DIV rounds to an integer.
  - The period is exactly div_int.

## Structure
- Package baud_pkg holds:
  - the RST_DIV computation function;
  - the clamp constant MIN_DIV = 2;
  - the default widths.
- Sub-module baud_frac_acc isolates the accumulator/carry logic and is instantiated only under BAUD_FRAC_EN.
- The top level contains the counters, the shadow registers and the handshake.

## Test plan
- Reset defaults, enable high, BAUD_FRAC_EN on:
  - 1000 tick_o pulses span 65104 ±1 clocks;
  - bit_tick_o fires on every 16th tick_o.
- Write cfg_int=10, cfg_frac=128 (FRAC_W 8) mid-period:
  - busy_o high until the next tick;
  - periods then alternate 10/11 clocks;
  - cfg_ready_o is low while busy, and a second offer is held off.
- cfg_int=1:
  - the clamp applies, and tick_o asserts every 2 clocks with frac 0.
- sync_i pulsed 5 cycles before an expected tick:
  - no tick in that cycle;
  - the next tick comes div_int cycles later;
  - os_cnt restarts, so bit_tick_o follows after 16 ticks.
- enable_i low for 100 cycles mid-period:
  - no ticks;
  - resuming completes the remaining count exactly;
  - a config offered while disabled applies within 1 cycle.
- reset_n_i asserted asynchronously mid-period with busy_o high:
  - outputs zero immediately;
  - after release, behaviour matches the default divisor and the staged value is lost.
